nmod_counter: RTL

//   Parametrised up/down counter: next generation of the 16-bit lab counter.

---
 rtl/nmod_counter.sv | 68 ++++++
 1 files changed

// File: rtl/nmod_counter.sv
// rtl/nmod_counter.sv - parametrised up/down modulo counter with prescaler, load, terminal count and sticky overflow
module nmod_counter #(
    parameter int              WIDTH    = 16,
    parameter longint unsigned MODULUS  = 65536,
    parameter bit              SATURATE = 1'b0,
    parameter int              DIV      = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             E,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX_Q     = WIDTH'(MODULUS - 64'd1);
    // DIV=1 still gets a 1-bit prescaler that never leaves 0, so every enabled cycle steps
    localparam int               PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PCNT_LAST = PW'(DIV - 1);

    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_pcnt;
    logic             r_tc;
    logic             r_ovf;

    logic             w_step;
    logic             w_at_bnd;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next_q;

    assign w_step     = E && (r_pcnt == PCNT_LAST);
    assign w_at_bnd   = up_dn ? (r_q == MAX_Q) : (r_q == '0);
    assign w_load_val = (64'(D) >= MODULUS) ? MAX_Q : D;

    always_comb begin
        w_next_q = r_q;
        if (!w_at_bnd)
            w_next_q = up_dn ? r_q + 1'b1 : r_q - 1'b1;
        else if (!SATURATE)
            w_next_q = up_dn ? '0 : MAX_Q;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_q    <= '0;
            r_pcnt <= '0;
            r_tc   <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_val;
            r_pcnt <= '0;
            r_tc   <= 1'b0;
        end else begin
            if (E)
                r_pcnt <= w_step ? '0 : r_pcnt + 1'b1;
            if (w_step)
                r_q <= w_next_q;
            r_tc  <= w_step && w_at_bnd;
            r_ovf <= r_ovf || (w_step && w_at_bnd);
        end
    end

    assign Q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;
endmodule
